// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multicycle main controller and the MCCPU
// datapath.
//   Decode inputs  : Op, Funct (IR fields), Zero (ALU flag), mem_rdy (memory done)
//   Control outputs: PCWrite, NPCOp, IorD, MemRd, DMWr, IRWrite, RFWr, GPRSel,
//                    WDSel, EXTOp, ALUSrcA, ALUSrcB, ALUOp, retire, illegal
// The master modport is the controller; the slave modport is the datapath.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_rdy;

  logic       PCWrite;
  logic [1:0] NPCOp;
  logic       IorD;
  logic       MemRd;
  logic       DMWr;
  logic       IRWrite;
  logic       RFWr;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;
  logic       EXTOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic       retire;
  logic       illegal;

  modport master (
    input  Op, Funct, Zero, mem_rdy,
    output PCWrite, NPCOp, IorD, MemRd, DMWr, IRWrite, RFWr, GPRSel, WDSel,
           EXTOp, ALUSrcA, ALUSrcB, ALUOp, retire, illegal
  );

  modport slave (
    output Op, Funct, Zero, mem_rdy,
    input  PCWrite, NPCOp, IorD, MemRd, DMWr, IRWrite, RFWr, GPRSel, WDSel,
           EXTOp, ALUSrcA, ALUSrcB, ALUOp, retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main controller for the MCCPU. Steps each instruction
// through IF/ID/EXE/MEM/WB, driving the shared ALU, register file, IR/PC and
// unified memory. Waits in IF and MEM until mem_rdy, pulses retire on an
// instruction's last cycle and illegal when ID sees an unsupported encoding.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (returns to IF, masks all enables)
//   bus  : mc_ctrl_if.master, decode inputs in, control outputs out
// Outputs are combinational from state, Op, Funct, Zero and mem_rdy.
module mc_ctrl #(
  parameter int PC_INC = 4
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);

  localparam logic [3:0] ALU_NOP  = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,
                         ALU_AND  = 4'd3,  ALU_OR   = 4'd4,  ALU_XOR  = 4'd5,
                         ALU_NOR  = 4'd6,  ALU_SLT  = 4'd7,  ALU_SLTU = 4'd8,
                         ALU_SLL  = 4'd9,  ALU_SRL  = 4'd10, ALU_SRA  = 4'd11,
                         ALU_SLLV = 4'd12, ALU_SRLV = 4'd13, ALU_SRAV = 4'd14,
                         ALU_LUI  = 4'd15;

  // ALUSrcB=01 selects a hard-wired increment in the datapath; the IF sequence
  // here only makes sense when that constant is one instruction word.
  if (PC_INC != 4) begin : gBadPcInc
    $error("mc_ctrl assumes PC_INC == 4");
  end

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic       rAlu, rShift, rJr, rJalr;
  logic       opJ, opJal, opBr, opLw, opSw, opIAlu, iSigned, legal;
  logic [3:0] rAluOp, iAluOp;

  logic       pcWrite, iorD, memRd, dmWr, irWrite, rfWr, extOp, retire, illegal;
  logic [1:0] npcOp, gprSel, wdSel, aluSrcA, aluSrcB;
  logic [3:0] aluOp;

  // Instruction decode. SRA deliberately maps to ALU_SRAV: the shamt is routed
  // into the A port, so the variable-shift unit does the work.
  always_comb begin
    rAlu   = 1'b0;
    rShift = 1'b0;
    rAluOp = ALU_NOP;
    case (bus.Funct)
      6'h20, 6'h21: begin rAlu = 1'b1; rAluOp = ALU_ADD;  end
      6'h22, 6'h23: begin rAlu = 1'b1; rAluOp = ALU_SUB;  end
      6'h24:        begin rAlu = 1'b1; rAluOp = ALU_AND;  end
      6'h25:        begin rAlu = 1'b1; rAluOp = ALU_OR;   end
      6'h26:        begin rAlu = 1'b1; rAluOp = ALU_XOR;  end
      6'h27:        begin rAlu = 1'b1; rAluOp = ALU_NOR;  end
      6'h2A:        begin rAlu = 1'b1; rAluOp = ALU_SLT;  end
      6'h2B:        begin rAlu = 1'b1; rAluOp = ALU_SLTU; end
      6'h04:        begin rAlu = 1'b1; rAluOp = ALU_SLLV; end
      6'h06:        begin rAlu = 1'b1; rAluOp = ALU_SRLV; end
      6'h07:        begin rAlu = 1'b1; rAluOp = ALU_SRAV; end
      6'h00:        begin rShift = 1'b1; rAluOp = ALU_SLL;  end
      6'h02:        begin rShift = 1'b1; rAluOp = ALU_SRL;  end
      6'h03:        begin rShift = 1'b1; rAluOp = ALU_SRAV; end
      default:      ;
    endcase
    if (bus.Op != 6'h00) begin
      rAlu   = 1'b0;
      rShift = 1'b0;
    end
    rJr   = (bus.Op == 6'h00) && (bus.Funct == 6'h08);
    rJalr = (bus.Op == 6'h00) && (bus.Funct == 6'h09);

    opIAlu  = 1'b1;
    iSigned = 1'b0;
    iAluOp  = ALU_NOP;
    case (bus.Op)
      6'h08, 6'h09: begin iSigned = 1'b1; iAluOp = ALU_ADD;  end
      6'h0A:        begin iSigned = 1'b1; iAluOp = ALU_SLT;  end
      6'h0B:        begin iSigned = 1'b1; iAluOp = ALU_SLTU; end
      6'h0C:        iAluOp = ALU_AND;
      6'h0D:        iAluOp = ALU_OR;
      6'h0E:        iAluOp = ALU_XOR;
      6'h0F:        iAluOp = ALU_LUI;
      default:      opIAlu = 1'b0;
    endcase

    opJ   = (bus.Op == 6'h02);
    opJal = (bus.Op == 6'h03);
    opBr  = (bus.Op == 6'h04) || (bus.Op == 6'h05);
    opLw  = (bus.Op == 6'h23);
    opSw  = (bus.Op == 6'h2B);
    legal = rAlu | rShift | rJr | rJalr | opIAlu | opJ | opJal | opBr | opLw | opSw;
  end

  // Per-state control generation and next-state selection. Everything not set
  // in a state stays 0 (ALUOp stays NOP).
  always_comb begin
    pcWrite = 1'b0;  npcOp   = 2'b00; iorD    = 1'b0;  memRd   = 1'b0;
    dmWr    = 1'b0;  irWrite = 1'b0;  rfWr    = 1'b0;  gprSel  = 2'b00;
    wdSel   = 2'b00; extOp   = 1'b0;  aluSrcA = 2'b00; aluSrcB = 2'b00;
    aluOp   = ALU_NOP; retire = 1'b0; illegal = 1'b0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        memRd   = 1'b1;
        aluSrcB = 2'b01;
        aluOp   = ALU_ADD;
        irWrite = bus.mem_rdy;
        pcWrite = bus.mem_rdy;
        state_d = bus.mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target PC+4+(imm<<2) is computed here while decode settles.
        aluSrcB = 2'b11;
        extOp   = 1'b1;
        aluOp   = ALU_ADD;
        if (!legal) begin
          illegal = 1'b1;
        end else if (opJ || opJal) begin
          pcWrite = 1'b1;
          npcOp   = 2'b10;
          retire  = 1'b1;
          if (opJal) begin
            rfWr   = 1'b1;
            gprSel = 2'b10;
            wdSel  = 2'b10;
          end
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (rJr || rJalr) begin
          pcWrite = 1'b1;
          npcOp   = 2'b11;
          retire  = 1'b1;
          if (rJalr) begin
            rfWr  = 1'b1;
            wdSel = 2'b10;
          end
        end else if (rAlu || rShift) begin
          aluSrcA = rShift ? 2'b10 : 2'b01;
          aluOp   = rAluOp;
          state_d = S_WB;
        end else if (opIAlu) begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b10;
          extOp   = iSigned;
          aluOp   = iAluOp;
          state_d = S_WB;
        end else if (opLw || opSw) begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b10;
          extOp   = 1'b1;
          aluOp   = ALU_ADD;
          state_d = S_MEM;
        end else if (opBr) begin
          aluSrcA = 2'b01;
          aluOp   = ALU_SUB;
          npcOp   = 2'b01;
          pcWrite = (bus.Op == 6'h04) ? bus.Zero : !bus.Zero;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        // Request lines stay up for the whole access, including wait cycles.
        iorD = 1'b1;
        if (opLw) begin
          memRd   = 1'b1;
          state_d = bus.mem_rdy ? S_WB : S_MEM;
        end else if (opSw) begin
          dmWr    = 1'b1;
          retire  = bus.mem_rdy;
          state_d = bus.mem_rdy ? S_IF : S_MEM;
        end
      end
      S_WB: begin
        rfWr   = 1'b1;
        retire = 1'b1;
        gprSel = (bus.Op == 6'h00) ? 2'b00 : 2'b01;
        wdSel  = opLw ? 2'b01 : 2'b00;
      end
      default: state_d = S_IF;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Enables are masked during reset; selects pass through unchanged.
  assign bus.PCWrite = pcWrite & ~rst;
  assign bus.IRWrite = irWrite & ~rst;
  assign bus.RFWr    = rfWr    & ~rst;
  assign bus.DMWr    = dmWr    & ~rst;
  assign bus.MemRd   = memRd   & ~rst;
  assign bus.retire  = retire  & ~rst;
  assign bus.illegal = illegal & ~rst;
  assign bus.NPCOp   = npcOp;
  assign bus.IorD    = iorD;
  assign bus.GPRSel  = gprSel;
  assign bus.WDSel   = wdSel;
  assign bus.EXTOp   = extOp;
  assign bus.ALUSrcA = aluSrcA;
  assign bus.ALUSrcB = aluSrcB;
  assign bus.ALUOp   = aluOp;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: drives instruction sequences (directed then random) into mc_ctrl
// and compares every cycle's control vector against a phase-level model built
// from opcode tables. Also checks the number of retire pulses per instruction.
module tb_mc_ctrl;

  localparam logic [3:0] ALU_NOP  = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,
                         ALU_AND  = 4'd3,  ALU_OR   = 4'd4,  ALU_XOR  = 4'd5,
                         ALU_NOR  = 4'd6,  ALU_SLT  = 4'd7,  ALU_SLTU = 4'd8,
                         ALU_SLL  = 4'd9,  ALU_SRL  = 4'd10, ALU_SLLV = 4'd12,
                         ALU_SRLV = 4'd13, ALU_SRAV = 4'd14, ALU_LUI  = 4'd15;

  typedef enum int {PH_IF, PH_ID, PH_EXE, PH_MEM, PH_WB} phase_e;
  typedef enum int {K_ILL, K_J, K_JAL, K_BR, K_JR, K_JALR, K_R, K_I, K_LW, K_SW} kind_e;

  logic clk = 1'b0;
  logic rst;
  mc_ctrl_if bus();

  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Opcode tables: R-type by Funct, I-type ALU by Op.
  logic [3:0] rOpTab [64];
  bit         rKnown [64];
  bit         rShamt [64];
  logic [3:0] iOpTab [64];
  bit         iKnown [64];
  bit         iSext  [64];

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic initTables();
    for (int i = 0; i < 64; i++) begin
      rKnown[i] = 0; rShamt[i] = 0; rOpTab[i] = ALU_NOP;
      iKnown[i] = 0; iSext[i]  = 0; iOpTab[i] = ALU_NOP;
    end
    rOpTab[6'h20] = ALU_ADD;  rOpTab[6'h21] = ALU_ADD;
    rOpTab[6'h22] = ALU_SUB;  rOpTab[6'h23] = ALU_SUB;
    rOpTab[6'h24] = ALU_AND;  rOpTab[6'h25] = ALU_OR;
    rOpTab[6'h26] = ALU_XOR;  rOpTab[6'h27] = ALU_NOR;
    rOpTab[6'h2A] = ALU_SLT;  rOpTab[6'h2B] = ALU_SLTU;
    rOpTab[6'h04] = ALU_SLLV; rOpTab[6'h06] = ALU_SRLV; rOpTab[6'h07] = ALU_SRAV;
    rOpTab[6'h00] = ALU_SLL;  rOpTab[6'h02] = ALU_SRL;  rOpTab[6'h03] = ALU_SRAV;
    foreach (rKnown[i]) rKnown[i] = (rOpTab[i] != ALU_NOP);
    rShamt[6'h00] = 1; rShamt[6'h02] = 1; rShamt[6'h03] = 1;
    iOpTab[6'h08] = ALU_ADD; iOpTab[6'h09] = ALU_ADD;
    iOpTab[6'h0A] = ALU_SLT; iOpTab[6'h0B] = ALU_SLTU;
    iOpTab[6'h0C] = ALU_AND; iOpTab[6'h0D] = ALU_OR;
    iOpTab[6'h0E] = ALU_XOR; iOpTab[6'h0F] = ALU_LUI;
    foreach (iKnown[i]) iKnown[i] = (iOpTab[i] != ALU_NOP);
    iSext[6'h08] = 1; iSext[6'h09] = 1; iSext[6'h0A] = 1; iSext[6'h0B] = 1;
  endtask

  function automatic kind_e kindOf(input logic [5:0] op, input logic [5:0] funct);
    if (op == 6'h00) begin
      if (funct == 6'h08) return K_JR;
      if (funct == 6'h09) return K_JALR;
      return rKnown[funct] ? K_R : K_ILL;
    end
    case (op)
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04, 6'h05: return K_BR;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return iKnown[op] ? K_I : K_ILL;
    endcase
  endfunction

  // Expected control vector for one cycle of a given phase.
  function automatic logic [31:0] expCtrl(input phase_e ph, input logic [5:0] op,
                                          input logic [5:0] funct, input logic zero,
                                          input logic rdy, input logic r);
    logic pcW = 0, iorD = 0, memRd = 0, dmWr = 0, irW = 0, rfWr = 0;
    logic extOp = 0, ret = 0, ill = 0;
    logic [1:0] npc = 0, gpr = 0, wd = 0, srcA = 0, srcB = 0;
    logic [3:0] aluOp = ALU_NOP;
    kind_e k = kindOf(op, funct);
    case (ph)
      PH_IF: begin memRd = 1; srcB = 2'b01; aluOp = ALU_ADD; irW = rdy; pcW = rdy; end
      PH_ID: begin
        srcB = 2'b11; extOp = 1; aluOp = ALU_ADD;
        if (k == K_ILL) ill = 1;
        if (k == K_J || k == K_JAL) begin pcW = 1; npc = 2'b10; ret = 1; end
        if (k == K_JAL) begin rfWr = 1; gpr = 2'b10; wd = 2'b10; end
      end
      PH_EXE: begin
        case (k)
          K_R: begin srcA = rShamt[funct] ? 2'b10 : 2'b01; aluOp = rOpTab[funct]; end
          K_I: begin srcA = 2'b01; srcB = 2'b10; extOp = iSext[op]; aluOp = iOpTab[op]; end
          K_LW, K_SW: begin srcA = 2'b01; srcB = 2'b10; extOp = 1; aluOp = ALU_ADD; end
          K_BR: begin
            srcA = 2'b01; aluOp = ALU_SUB; npc = 2'b01; ret = 1;
            pcW = (op == 6'h04) ? zero : ~zero;
          end
          K_JR, K_JALR: begin
            pcW = 1; npc = 2'b11; ret = 1;
            if (k == K_JALR) begin rfWr = 1; wd = 2'b10; end
          end
          default: ;
        endcase
      end
      PH_MEM: begin
        iorD = 1;
        if (k == K_LW) memRd = 1;
        if (k == K_SW) begin dmWr = 1; ret = rdy; end
      end
      PH_WB: begin
        rfWr = 1; ret = 1;
        gpr = (k == K_R) ? 2'b00 : 2'b01;
        wd  = (k == K_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    if (r) begin pcW = 0; irW = 0; rfWr = 0; dmWr = 0; memRd = 0; ret = 0; ill = 0; end
    return {9'd0, pcW, npc, iorD, memRd, dmWr, irW, rfWr, gpr, wd, extOp,
            srcA, srcB, aluOp, ret, ill};
  endfunction

  function automatic logic [31:0] observed();
    return {9'd0, bus.PCWrite, bus.NPCOp, bus.IorD, bus.MemRd, bus.DMWr,
            bus.IRWrite, bus.RFWr, bus.GPRSel, bus.WDSel, bus.EXTOp,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.retire, bus.illegal};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%06h, want 0x%06h", tag, actual, expected);
  endtask

  // One cycle: drive inputs after the falling edge, let outputs settle.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic zero, input logic rdy, input logic r);
    @(negedge clk);
    bus.Op = op; bus.Funct = funct; bus.Zero = zero; bus.mem_rdy = rdy; rst = r;
    #1;
  endtask

  // Walks one instruction through its phases, checking every cycle.
  task automatic runInstr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                          input logic zero, input int ifWaits, input int memWaits);
    kind_e k = kindOf(op, funct);
    int retires = 0;
    logic rdy;
    for (int i = 0; i <= ifWaits; i++) begin
      rdy = (i == ifWaits);
      applyStimulus(6'($urandom), 6'($urandom), 1'($urandom), rdy, 1'b0);
      checkOutput({tag, " IF"}, observed(), expCtrl(PH_IF, op, funct, zero, rdy, 1'b0));
      retires += int'(bus.retire);
    end
    rdy = 1'($urandom);
    applyStimulus(op, funct, zero, rdy, 1'b0);
    checkOutput({tag, " ID"}, observed(), expCtrl(PH_ID, op, funct, zero, rdy, 1'b0));
    retires += int'(bus.retire);
    if (!(k inside {K_ILL, K_J, K_JAL})) begin
      rdy = 1'($urandom);
      applyStimulus(op, funct, zero, rdy, 1'b0);
      checkOutput({tag, " EXE"}, observed(), expCtrl(PH_EXE, op, funct, zero, rdy, 1'b0));
      retires += int'(bus.retire);
      if (k inside {K_LW, K_SW}) begin
        for (int i = 0; i <= memWaits; i++) begin
          rdy = (i == memWaits);
          applyStimulus(op, funct, zero, rdy, 1'b0);
          checkOutput({tag, " MEM"}, observed(), expCtrl(PH_MEM, op, funct, zero, rdy, 1'b0));
          retires += int'(bus.retire);
        end
      end
      if (k inside {K_R, K_I, K_LW}) begin
        rdy = 1'($urandom);
        applyStimulus(op, funct, zero, rdy, 1'b0);
        checkOutput({tag, " WB"}, observed(), expCtrl(PH_WB, op, funct, zero, rdy, 1'b0));
        retires += int'(bus.retire);
      end
    end
    checkOutput({tag, " retires"}, 32'(retires), (k == K_ILL) ? 32'd0 : 32'd1);
  endtask

  // LW stalled in MEM, then reset held for two cycles.
  task automatic resetMidLw();
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rstLw IF", observed(), expCtrl(PH_IF, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0));
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rstLw ID", observed(), expCtrl(PH_ID, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0));
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rstLw EXE", observed(), expCtrl(PH_EXE, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0));
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rstLw MEM", observed(), expCtrl(PH_MEM, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0));
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rstLw rst1", observed(), expCtrl(PH_MEM, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1));
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rstLw rst2", observed(), expCtrl(PH_IF, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1));
  endtask

  logic [5:0] legalOps   [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                  6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
  logic [5:0] legalFuncts[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h00,
                                  6'h02, 6'h03, 6'h08, 6'h09};

  initial begin
    logic [5:0] op, funct;
    initTables();
    bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_rdy = 1'b0; rst = 1'b1;

    // Power-on reset: state is defined from the second reset cycle on.
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("por", observed(), expCtrl(PH_IF, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1));

    runInstr("add",   6'h00, 6'h20, 1'b0, 0, 0);
    runInstr("lw",    6'h23, 6'h00, 1'b0, 0, 3);
    runInstr("beqT",  6'h04, 6'h00, 1'b1, 0, 0);
    runInstr("beqN",  6'h04, 6'h00, 1'b0, 0, 0);
    runInstr("bneT",  6'h05, 6'h00, 1'b0, 0, 0);
    runInstr("bneN",  6'h05, 6'h00, 1'b1, 0, 0);
    runInstr("sll",   6'h00, 6'h00, 1'b0, 0, 0);
    runInstr("sra",   6'h00, 6'h03, 1'b0, 0, 0);
    runInstr("ill3f", 6'h3F, 6'h00, 1'b0, 0, 0);
    runInstr("illFn", 6'h00, 6'h3F, 1'b0, 0, 0);
    runInstr("jal",   6'h03, 6'h00, 1'b0, 2, 0);
    runInstr("j",     6'h02, 6'h00, 1'b0, 0, 0);
    runInstr("jr",    6'h00, 6'h08, 1'b0, 0, 0);
    runInstr("jalr",  6'h00, 6'h09, 1'b0, 0, 0);
    runInstr("sw",    6'h2B, 6'h00, 1'b0, 1, 2);
    runInstr("lui",   6'h0F, 6'h00, 1'b0, 0, 0);
    runInstr("ori",   6'h0D, 6'h00, 1'b0, 0, 0);
    runInstr("slti",  6'h0A, 6'h00, 1'b0, 0, 0);

    resetMidLw();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom); funct = 6'($urandom);
      end else begin
        op = ($urandom_range(0, 9) == 0) ? 6'h2B : legalOps[$urandom_range(0, 13)];
        funct = (op == 6'h00) ? legalFuncts[$urandom_range(0, 17)] : 6'($urandom);
      end
      runInstr($sformatf("rnd%0d", n), op, funct, 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
